// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART buffer definitions: entry width, default depth and the FIFO operation encoding.
// Used by the receive buffer now and by the transmit buffer later.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;

  // Bit 1 = write accepted this cycle, bit 0 = read accepted this cycle.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver/host-side bus of the UART receive FIFO.
// The level signal exists only when UART_RX_FIFO_LEVEL_EN is defined.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
);

  logic              wr;
  logic [DATA_W-1:0] w_data;
  logic              rd;
  logic              clr_ovr;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic              full;
  logic              overrun;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [ADDR_W:0]   level;

  modport master (
    output wr, w_data, rd, clr_ovr,
    input  r_data, empty, full, overrun, level
  );

  modport slave (
    input  wr, w_data, rd, clr_ovr,
    output r_data, empty, full, overrun, level
  );
`else
  modport master (
    output wr, w_data, rd, clr_ovr,
    input  r_data, empty, full, overrun
  );

  modport slave (
    input  wr, w_data, rd, clr_ovr,
    output r_data, empty, full, overrun
  );
`endif

endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// fifo_ctrl: pointer, empty/full flag and optional level state for a 2**ADDR_W-entry FIFO.
// Level counter is built only when UART_RX_FIFO_LEVEL_EN is defined.
module fifo_ctrl
  import uart_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              empty,
  output logic              full,
  output logic              we
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level
`endif
);

  logic [ADDR_W-1:0] w_ptr_q, w_ptr_n;
  logic [ADDR_W-1:0] r_ptr_q, r_ptr_n;
  logic              empty_q, empty_n;
  logic              full_q, full_n;
  logic              wr_ok, rd_ok;
  fifo_op_e          op;

  assign rd_ok = rd && !empty_q;
  // A write into a full FIFO still lands when a read frees the head slot in the same cycle.
  assign wr_ok = wr && (!full_q || rd_ok);
  assign op    = fifo_op_e'({wr_ok, rd_ok});

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_n;
      r_ptr_q <= r_ptr_n;
      empty_q <= empty_n;
      full_q  <= full_n;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path leaves a latch behind.
  always_comb begin
    w_ptr_n = w_ptr_q;
    r_ptr_n = r_ptr_q;
    empty_n = empty_q;
    full_n  = full_q;
    case (op)
      OP_WRITE: begin
        w_ptr_n = w_ptr_q + 1'b1;
        empty_n = 1'b0;
        full_n  = (w_ptr_n == r_ptr_q);
      end
      OP_READ: begin
        r_ptr_n = r_ptr_q + 1'b1;
        full_n  = 1'b0;
        empty_n = (r_ptr_n == w_ptr_q);
      end
      OP_BOTH: begin
        w_ptr_n = w_ptr_q + 1'b1;
        r_ptr_n = r_ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign w_addr = w_ptr_q;
  assign r_addr = r_ptr_q;
  assign empty  = empty_q;
  assign full   = full_q;
  assign we     = wr_ok;

`ifdef UART_RX_FIFO_LEVEL_EN
  logic [ADDR_W:0] level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      case (op)
        OP_WRITE: level_q <= level_q + 1'b1;
        OP_READ:  level_q <= level_q - 1'b1;
        default:  ;
      endcase
    end
  end

  assign level = level_q;
`endif

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: first-word-fall-through FIFO with sticky overrun flag.
// Define UART_RX_FIFO_LEVEL_EN to add the registered occupancy count on bus.level.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic              empty, full, we;
  logic              drop;
  logic              overrun_q;

  fifo_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wr     (bus.wr),
    .rd     (bus.rd),
    .w_addr (w_addr),
    .r_addr (r_addr),
    .empty  (empty),
    .full   (full),
    .we     (we)
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    .level  (bus.level)
`endif
  );

  // NOTE: the storage array has no reset; the flags alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= bus.w_data;
    end
  end

  // A byte is lost only when full and no read makes room for it.
  assign drop = bus.wr && full && !bus.rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (bus.clr_ovr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.r_data  = mem[r_addr];
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences and
// randomized traffic compared against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  uart_rx_fifo #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] model_q[$];
  bit         model_ovr;

  typedef struct {
    bit         wr;
    logic [7:0] wd;
    bit         rd;
    bit         clr;
    bit         e_empty;
    bit         e_full;
    bit         e_ovr;
    bit         chk_data;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    check({tag, ".full"}, 32'(bus.full), 32'(model_q.size() == DEPTH));
    check({tag, ".overrun"}, 32'(bus.overrun), 32'(model_ovr));
    if (model_q.size() != 0) begin
      check({tag, ".r_data"}, 32'(bus.r_data), 32'(model_q[0]));
    end
`ifdef UART_RX_FIFO_LEVEL_EN
    check({tag, ".level"}, 32'(bus.level), 32'(model_q.size()));
`endif
  endtask

  // One clock of stimulus; the model then applies the buffer rules to its queue.
  task automatic step(input bit wr, input logic [7:0] wd, input bit rd, input bit clr,
                      input string tag);
    bit can_rd, can_wr;
    bus.wr      = wr;
    bus.w_data  = wd;
    bus.rd      = rd;
    bus.clr_ovr = clr;
    @(posedge clk);
    #1;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.clr_ovr = 1'b0;
    can_rd = (model_q.size() > 0);
    can_wr = (model_q.size() < DEPTH) || (rd && can_rd);
    if (rd && can_rd) void'(model_q.pop_front());
    if (wr && can_wr) model_q.push_back(wd);
    if (wr && !can_wr) model_ovr = 1'b1;
    else if (clr) model_ovr = 1'b0;
    compare_model(tag);
  endtask

  // Asserts reset away from the clock edge and checks the flags clear before any edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_q.delete();
    model_ovr = 1'b0;
    check({tag, ".empty"}, 32'(bus.empty), 32'd1);
    check({tag, ".full"}, 32'(bus.full), 32'd0);
    check({tag, ".overrun"}, 32'(bus.overrun), 32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    check({tag, ".level"}, 32'(bus.level), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare_model({tag, ".after"});
  endtask

  initial begin
    bus.wr      = 1'b0;
    bus.w_data  = '0;
    bus.rd      = 1'b0;
    bus.clr_ovr = 1'b0;
    model_ovr   = 1'b0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic push/pop, read while empty, simultaneous wr/rd on an empty FIFO.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr, $sformatf("vec%0d.model", i));
      check($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(tbl[i].e_empty));
      check($sformatf("vec%0d.full", i), 32'(bus.full), 32'(tbl[i].e_full));
      check($sformatf("vec%0d.overrun", i), 32'(bus.overrun), 32'(tbl[i].e_ovr));
      if (tbl[i].chk_data) begin
        check($sformatf("vec%0d.r_data", i), 32'(bus.r_data), 32'(tbl[i].e_data));
      end
    end

    // Fill to full, drop a 17th byte, clear overrun against a coincident drop, drain.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      if (i == DEPTH - 2) check("fill.not_full_at_15", 32'(bus.full), 32'd0);
    end
    check("fill.full_at_16", 32'(bus.full), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, "drop");
    check("drop.overrun", 32'(bus.overrun), 32'd1);
    check("drop.head", 32'(bus.r_data), 32'h00);
    step(1'b1, 8'hEE, 1'b0, 1'b1, "clr_vs_drop");
    check("clr_vs_drop.overrun", 32'(bus.overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_alone");
    check("clr_alone.overrun", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain1.byte%0d", i), 32'(bus.r_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, "drain1");
    end
    check("drain1.empty", 32'(bus.empty), 32'd1);

    // Full FIFO with simultaneous wr/rd: both happen, no overrun.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "refill");
    step(1'b1, 8'h77, 1'b1, 1'b0, "full_wr_rd");
    check("full_wr_rd.full", 32'(bus.full), 32'd1);
    check("full_wr_rd.overrun", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain2.byte%0d", i), 32'(bus.r_data),
            (i < DEPTH - 1) ? 32'(8'h11 + i) : 32'h77);
      step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    end
    check("drain2.empty", 32'(bus.empty), 32'd1);

    // Reset while full with overrun set.
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "prereset");
    apply_reset("midreset");

    // Pointer wrap: 40 writes of an incrementing byte interleaved with reads.
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), (i % 4) != 0, 1'b0, "wrap");
    for (int i = 0; i < DEPTH && model_q.size() != 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
    check("wrap.empty", 32'(bus.empty), 32'd1);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 400; i++) begin
      bit fill_phase;
      bit r_wr, r_rd, r_clr;
      fill_phase = ((i / 50) % 2) == 0;
      r_wr  = $urandom_range(0, 99) < (fill_phase ? 80 : 25);
      r_rd  = $urandom_range(0, 99) < (fill_phase ? 25 : 80);
      r_clr = $urandom_range(0, 15) == 0;
      step(r_wr, 8'($urandom), r_rd, r_clr, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
